// File: rtl/wb_regfile_fwd_pkg.sv
// Shared widths and operand-source encoding for the write-back stage and
// register file with decode-stage forwarding.
package wb_regfile_fwd_pkg;

    localparam int DSIZE_DEF = 16;
    localparam int ASIZE_DEF = 3;
    localparam int CNTW_DEF  = 16;

    typedef enum logic [1:0] {
        FWD_ARR  = 2'd0,
        FWD_WB   = 2'd1,
        FWD_EXE  = 2'd2,
        FWD_ZERO = 2'd3
    } fwd_sel_e;

endpackage

// File: rtl/wb_regfile_fwd_if.sv
// Bundle of the EXE/WB write inputs, decode read ports and debug counter.
// The pipeline drives through master; the register file block uses slave.
interface wb_regfile_fwd_if
    import wb_regfile_fwd_pkg::*;
#(
    parameter int DSIZE = DSIZE_DEF,
    parameter int ASIZE = ASIZE_DEF,
    parameter int CNTW  = CNTW_DEF
);

    logic             wb_wen;
    logic [ASIZE-1:0] wb_waddr;
    logic [DSIZE-1:0] wb_wdata;
    logic             exe_wen;
    logic [ASIZE-1:0] exe_waddr;
    logic [DSIZE-1:0] exe_result;
    logic [ASIZE-1:0] raddr1;
    logic [ASIZE-1:0] raddr2;
    logic [DSIZE-1:0] rdata1;
    logic [DSIZE-1:0] rdata2;
    fwd_sel_e         fwd_sel1;
    fwd_sel_e         fwd_sel2;
    logic [CNTW-1:0]  wr_count;

    modport master (
        output wb_wen, wb_waddr, wb_wdata,
        output exe_wen, exe_waddr, exe_result,
        output raddr1, raddr2,
        input  rdata1, rdata2, fwd_sel1, fwd_sel2, wr_count
    );

    modport slave (
        input  wb_wen, wb_waddr, wb_wdata,
        input  exe_wen, exe_waddr, exe_result,
        input  raddr1, raddr2,
        output rdata1, rdata2, fwd_sel1, fwd_sel2, wr_count
    );

endinterface

// File: rtl/wb_regfile_fwd_regfile_core.sv
// Architectural register storage: synchronous reset, one write port and two
// combinational read ports. R0 protection is handled by the caller.
module wb_regfile_fwd_regfile_core #(
    parameter int DSIZE = 16,
    parameter int ASIZE = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_wen,
    input  logic [ASIZE-1:0] i_waddr,
    input  logic [DSIZE-1:0] i_wdata,
    input  logic [ASIZE-1:0] i_raddr1,
    input  logic [ASIZE-1:0] i_raddr2,
    output logic [DSIZE-1:0] o_rdata1,
    output logic [DSIZE-1:0] o_rdata2
);

    localparam int NREG = 1 << ASIZE;

    logic [DSIZE-1:0] r_mem [NREG];

    // NOTE: the whole array is reset (not just the valid state) so that
    // never-written registers read a defined zero instead of X.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                // NOTE: non-blocking so every register samples pre-edge values.
                r_mem[i] <= '0;
            end
        end else if (i_wen) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata1 = r_mem[i_raddr1];
    assign o_rdata2 = r_mem[i_raddr2];

endmodule

// File: rtl/wb_regfile_fwd.sv
// Write-back commit, register file and two forwarded decode operands
// (EXE result > pending WB write > stored value, R0 reads zero).
module wb_regfile_fwd
    import wb_regfile_fwd_pkg::*;
#(
    parameter int DSIZE = DSIZE_DEF,
    parameter int ASIZE = ASIZE_DEF,
    parameter int CNTW  = CNTW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    wb_regfile_fwd_if.slave bus
);

    logic             w_commit;
    logic [DSIZE-1:0] w_arr   [2];
    logic [ASIZE-1:0] w_raddr [2];
    logic [DSIZE-1:0] w_rdata [2];
    fwd_sel_e         w_sel   [2];
    logic [CNTW-1:0]  r_wr_count;

    assign w_commit   = bus.wb_wen && (bus.wb_waddr != '0);
    assign w_raddr[0] = bus.raddr1;
    assign w_raddr[1] = bus.raddr2;

    wb_regfile_fwd_regfile_core #(
        .DSIZE (DSIZE),
        .ASIZE (ASIZE)
    ) u_core (
        .clk      (clk),
        .rst      (rst),
        .i_wen    (w_commit),
        .i_waddr  (bus.wb_waddr),
        .i_wdata  (bus.wb_wdata),
        .i_raddr1 (bus.raddr1),
        .i_raddr2 (bus.raddr2),
        .o_rdata1 (w_arr[0]),
        .o_rdata2 (w_arr[1])
    );

    // EXE holds the younger instruction, so it wins over a same-address WB.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            // NOTE: defaults first on every path keep this purely combinational.
            w_sel[p]   = FWD_ARR;
            w_rdata[p] = w_arr[p];
            if (w_raddr[p] == '0) begin
                w_sel[p]   = FWD_ZERO;
                w_rdata[p] = '0;
            end else if (bus.exe_wen && (bus.exe_waddr == w_raddr[p])) begin
                w_sel[p]   = FWD_EXE;
                w_rdata[p] = bus.exe_result;
            end else if (bus.wb_wen && (bus.wb_waddr == w_raddr[p])) begin
                w_sel[p]   = FWD_WB;
                w_rdata[p] = bus.wb_wdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_count <= '0;
        end else if (w_commit) begin
            r_wr_count <= r_wr_count + CNTW'(1);
        end
    end

    assign bus.rdata1   = w_rdata[0];
    assign bus.rdata2   = w_rdata[1];
    assign bus.fwd_sel1 = w_sel[0];
    assign bus.fwd_sel2 = w_sel[1];
    assign bus.wr_count = r_wr_count;

endmodule

// File: tb/tb_wb_regfile_fwd.sv
// Self-checking bench for wb_regfile_fwd: directed vector table, reset and
// counter-wrap sequences, then random traffic against an array-based model.
module tb_wb_regfile_fwd;
    import wb_regfile_fwd_pkg::*;

    logic clk;
    logic rst;

    wb_regfile_fwd_if #(.DSIZE(16), .ASIZE(3), .CNTW(16)) bus  ();
    wb_regfile_fwd_if #(.DSIZE(16), .ASIZE(3), .CNTW(4))  bus4 ();

    wb_regfile_fwd #(.DSIZE(16), .ASIZE(3), .CNTW(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    wb_regfile_fwd #(.DSIZE(16), .ASIZE(3), .CNTW(4)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4.slave)
    );

    // Narrow-counter instance sees the same stimulus
    assign bus4.wb_wen     = bus.wb_wen;
    assign bus4.wb_waddr   = bus.wb_waddr;
    assign bus4.wb_wdata   = bus.wb_wdata;
    assign bus4.exe_wen    = bus.exe_wen;
    assign bus4.exe_waddr  = bus.exe_waddr;
    assign bus4.exe_result = bus.exe_result;
    assign bus4.raddr1     = bus.raddr1;
    assign bus4.raddr2     = bus.raddr2;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        wb_wen;
        logic [2:0]  wb_waddr;
        logic [15:0] wb_wdata;
        logic        exe_wen;
        logic [2:0]  exe_waddr;
        logic [15:0] exe_result;
        logic [2:0]  ra1;
        logic [2:0]  ra2;
        logic [15:0] e_d1;
        logic [1:0]  e_s1;
        logic [15:0] e_d2;
        logic [1:0]  e_s2;
        logic [15:0] e_cnt;
    } vec_t;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [15:0] m_reg [8];
    int          m_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic r, input logic ww, input logic [2:0] wa,
                                input logic [15:0] wd, input logic ew, input logic [2:0] ea,
                                input logic [15:0] ed, input logic [2:0] a1, input logic [2:0] a2,
                                input logic [15:0] d1, input logic [1:0] s1,
                                input logic [15:0] d2, input logic [1:0] s2,
                                input logic [15:0] c);
        vec_t v;
        v.rst = r; v.wb_wen = ww; v.wb_waddr = wa; v.wb_wdata = wd;
        v.exe_wen = ew; v.exe_waddr = ea; v.exe_result = ed;
        v.ra1 = a1; v.ra2 = a2;
        v.e_d1 = d1; v.e_s1 = s1; v.e_d2 = d2; v.e_s2 = s2; v.e_cnt = c;
        return v;
    endfunction

    // Reference read: the first matching rule in the priority list decides
    function automatic void model_read(input vec_t v, input logic [2:0] ra,
                                       output logic [15:0] d, output logic [1:0] s);
        if (ra == 3'd0) begin
            d = 16'h0; s = 2'd3;
        end else if (v.exe_wen && v.exe_waddr == ra) begin
            d = v.exe_result; s = 2'd2;
        end else if (v.wb_wen && v.wb_waddr == ra) begin
            d = v.wb_wdata; s = 2'd1;
        end else begin
            d = m_reg[ra]; s = 2'd0;
        end
    endfunction

    function automatic void model_edge(input vec_t v);
        if (v.rst) begin
            for (int i = 0; i < 8; i++) m_reg[i] = 16'h0;
            m_cnt = 0;
        end else if (v.wb_wen && v.wb_waddr != 3'd0) begin
            m_reg[v.wb_waddr] = v.wb_wdata;
            m_cnt = m_cnt + 1;
        end
    endfunction

    // Called at posedge+1: drive, settle, compare, then cross the next edge
    task automatic run_cycle(input vec_t v, input bit use_tbl, input string tag);
        logic [15:0] d1, d2;
        logic [1:0]  s1, s2;
        rst            = v.rst;
        bus.wb_wen     = v.wb_wen;
        bus.wb_waddr   = v.wb_waddr;
        bus.wb_wdata   = v.wb_wdata;
        bus.exe_wen    = v.exe_wen;
        bus.exe_waddr  = v.exe_waddr;
        bus.exe_result = v.exe_result;
        bus.raddr1     = v.ra1;
        bus.raddr2     = v.ra2;
        #3;
        model_read(v, v.ra1, d1, s1);
        model_read(v, v.ra2, d2, s2);
        check({tag, " rdata1"}, 32'(bus.rdata1), 32'(d1));
        check({tag, " sel1"}, 32'(bus.fwd_sel1), 32'(s1));
        check({tag, " rdata2"}, 32'(bus.rdata2), 32'(d2));
        check({tag, " sel2"}, 32'(bus.fwd_sel2), 32'(s2));
        check({tag, " wr_count"}, 32'(bus.wr_count), 32'(m_cnt % 65536));
        check({tag, " wr_count4"}, 32'(bus4.wr_count), 32'(m_cnt % 16));
        if (use_tbl) begin
            check({tag, " tbl rdata1"}, 32'(bus.rdata1), 32'(v.e_d1));
            check({tag, " tbl sel1"}, 32'(bus.fwd_sel1), 32'(v.e_s1));
            check({tag, " tbl rdata2"}, 32'(bus.rdata2), 32'(v.e_d2));
            check({tag, " tbl sel2"}, 32'(bus.fwd_sel2), 32'(v.e_s2));
            check({tag, " tbl wr_count"}, 32'(bus.wr_count), 32'(v.e_cnt));
        end
        @(posedge clk);
        model_edge(v);
        #1;
    endtask

    function automatic vec_t idle(input logic [2:0] a1, input logic [2:0] a2);
        return mk(0, 0, 0, 16'h0, 0, 0, 16'h0, a1, a2, 16'h0, 2'd0, 16'h0, 2'd0, 16'h0);
    endfunction

    function automatic vec_t wr(input logic [2:0] a, input logic [15:0] d);
        return mk(0, 1, a, d, 0, 0, 16'h0, 0, 0, 16'h0, 2'd0, 16'h0, 2'd0, 16'h0);
    endfunction

    vec_t tbl [13];

    initial begin
        vec_t v;
        tbl[0]  = mk(0, 1, 3, 16'hBEEF, 0, 0, 16'h0,    3, 0, 16'hBEEF, 2'd1, 16'h0,    2'd3, 16'd0);
        tbl[1]  = mk(0, 0, 0, 16'h0,    0, 0, 16'h0,    3, 3, 16'hBEEF, 2'd0, 16'hBEEF, 2'd0, 16'd1);
        tbl[2]  = mk(0, 1, 0, 16'hFFFF, 1, 0, 16'h1234, 0, 0, 16'h0,    2'd3, 16'h0,    2'd3, 16'd1);
        tbl[3]  = mk(0, 0, 0, 16'h0,    0, 0, 16'h0,    0, 3, 16'h0,    2'd3, 16'hBEEF, 2'd0, 16'd1);
        tbl[4]  = mk(0, 1, 5, 16'h00BB, 1, 5, 16'h00AA, 5, 5, 16'h00AA, 2'd2, 16'h00AA, 2'd2, 16'd1);
        tbl[5]  = mk(0, 0, 0, 16'h0,    0, 0, 16'h0,    5, 5, 16'h00BB, 2'd0, 16'h00BB, 2'd0, 16'd2);
        tbl[6]  = mk(0, 1, 2, 16'h1234, 0, 0, 16'h0,    1, 2, 16'h0,    2'd0, 16'h1234, 2'd1, 16'd2);
        tbl[7]  = mk(0, 0, 0, 16'h0,    0, 0, 16'h0,    2, 2, 16'h1234, 2'd0, 16'h1234, 2'd0, 16'd3);
        tbl[8]  = mk(1, 1, 4, 16'h5555, 0, 0, 16'h0,    4, 3, 16'h5555, 2'd1, 16'hBEEF, 2'd0, 16'd3);
        tbl[9]  = mk(0, 0, 0, 16'h0,    0, 0, 16'h0,    4, 3, 16'h0,    2'd0, 16'h0,    2'd0, 16'd0);
        tbl[10] = mk(0, 0, 0, 16'h0,    1, 6, 16'h0A0A, 6, 7, 16'h0A0A, 2'd2, 16'h0,    2'd0, 16'd0);
        tbl[11] = mk(0, 1, 7, 16'h7777, 1, 6, 16'h0A0A, 6, 7, 16'h0A0A, 2'd2, 16'h7777, 2'd1, 16'd0);
        tbl[12] = mk(0, 0, 0, 16'h0,    0, 0, 16'h0,    7, 6, 16'h7777, 2'd0, 16'h0,    2'd0, 16'd1);

        v = idle(0, 0);
        v.rst = 1'b1;
        rst = 1'b1;
        bus.wb_wen = 0; bus.wb_waddr = 0; bus.wb_wdata = 0;
        bus.exe_wen = 0; bus.exe_waddr = 0; bus.exe_result = 0;
        bus.raddr1 = 0; bus.raddr2 = 0;
        @(posedge clk);
        model_edge(v);
        #1;

        for (int i = 0; i < 13; i++) run_cycle(tbl[i], 1'b1, $sformatf("vec%0d", i));

        // Fill every register, then pulse reset and confirm all read zero
        for (int i = 1; i < 8; i++) run_cycle(wr(3'(i), 16'(16'h1111 * i)), 1'b0, "fill");
        run_cycle(idle(1, 7), 1'b0, "filled");
        v = idle(0, 0);
        v.rst = 1'b1;
        run_cycle(v, 1'b0, "rst_pulse");
        for (int i = 0; i < 8; i++) begin
            run_cycle(idle(3'(i), 3'(7 - i)), 1'b0, "post_rst");
            check("post_rst rdata1 zero", 32'(bus.rdata1), 32'h0);
            check("post_rst wr_count zero", 32'(bus.wr_count), 32'h0);
        end

        // Sixteen commits wrap the 4-bit counter back to zero
        for (int i = 0; i < 16; i++) run_cycle(wr(3'(1 + (i % 7)), 16'(i)), 1'b0, "wrap");
        run_cycle(idle(0, 0), 1'b0, "wrap_done");
        check("wrap wr_count4", 32'(bus4.wr_count), 32'h0);
        check("wrap wr_count16", 32'(bus.wr_count), 32'd16);

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            v.rst        = ($urandom_range(0, 31) == 0);
            v.wb_wen     = 1'($urandom_range(0, 1));
            v.wb_waddr   = 3'($urandom_range(0, 7));
            v.wb_wdata   = 16'($urandom);
            v.exe_wen    = 1'($urandom_range(0, 1));
            v.exe_waddr  = 3'($urandom_range(0, 7));
            v.exe_result = 16'($urandom);
            v.ra1        = 3'($urandom_range(0, 7));
            v.ra2        = ($urandom_range(0, 3) == 0) ? v.ra1 : 3'($urandom_range(0, 7));
            run_cycle(v, 1'b0, "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
